// File: rtl/dns_pkg.sv
// Shared definitions for the DNS analyzer datapath: packet and header sizes,
// scheduler state encoding and DNS header field widths.
package dns_pkg;

    localparam int PKT_WIDTH = 4096;
    localparam int HDR_WIDTH = 96;

    // Scheduler state encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    // DNS header fields (RFC 1035), shared with the analyzer
    localparam int HDR_ID_W      = 16;
    localparam int HDR_FLAGS_W   = 16;
    localparam int HDR_QDCOUNT_W = 16;
    localparam int HDR_ANCOUNT_W = 16;
    localparam int HDR_NSCOUNT_W = 16;
    localparam int HDR_ARCOUNT_W = 16;

endpackage

// File: rtl/dns_analyzer_sched_rr_arbiter.sv
// Combinational round-robin winner select: searches from last_grant+1
// upwards (modulo NUM_SRC) and returns the first requesting index.
module rr_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int IDX_W   = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [IDX_W-1:0]   winner,
    output logic               any_req
);

    // First requester after last_grant wins; any_req doubles as "found"
    always_comb begin
        // NOTE: every output gets a default before the search so no path
        // through the loop leaves a value held, which would infer a latch.
        winner  = '0;
        any_req = 1'b0;
        for (int i = 1; i <= NUM_SRC; i++) begin
            if (!any_req && req[(int'(last_grant) + i) % NUM_SRC]) begin
                winner  = IDX_W'((int'(last_grant) + i) % NUM_SRC);
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dns_analyzer_sched.sv
// Shares one DNS packet analyzer between NUM_SRC sources: grants one source
// round-robin, issues its packet, then waits for completion or a watchdog
// timeout before granting again. Counts completed and abandoned packets.
module dns_analyzer_sched #(
    parameter int NUM_SRC        = 4,
    parameter int PKT_WIDTH      = dns_pkg::PKT_WIDTH,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_WIDTH      = 32,
    parameter int IDX_W          = $clog2(NUM_SRC)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_SRC*PKT_WIDTH-1:0] s_pkt,
    input  logic [NUM_SRC-1:0]           s_pkt_valid,
    output logic [NUM_SRC-1:0]           s_pkt_ack,
    output logic [PKT_WIDTH-1:0]         m_pkt,
    output logic                         m_pkt_valid,
    input  logic                         m_pkt_ready,
    output logic [IDX_W-1:0]             m_src_id,
    output logic                         busy,
    output logic                         timeout_pulse,
    output logic [CNT_WIDTH-1:0]         done_count,
    output logic [CNT_WIDTH-1:0]         timeout_count
);
    import dns_pkg::*;

    localparam int TMR_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]       state;
    logic [IDX_W-1:0] last_grant;
    logic [TMR_W-1:0] timer;
    logic [IDX_W-1:0] winner;
    logic             any_req;

    rr_arbiter #(
        .NUM_SRC (NUM_SRC),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req        (s_pkt_valid),
        .last_grant (last_grant),
        .winner     (winner),
        .any_req    (any_req)
    );

    // Scheduler FSM, packet register, watchdog timer and statistics
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state         <= ST_IDLE;
            last_grant    <= IDX_W'(NUM_SRC - 1);
            timer         <= '0;
            m_pkt         <= '0;
            m_src_id      <= '0;
            s_pkt_ack     <= '0;
            m_pkt_valid   <= 1'b0;
            busy          <= 1'b0;
            timeout_pulse <= 1'b0;
            done_count    <= '0;
            timeout_count <= '0;
        end else begin
            // Pulses last exactly one cycle unless re-armed below
            s_pkt_ack     <= '0;
            m_pkt_valid   <= 1'b0;
            timeout_pulse <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        m_pkt       <= s_pkt[int'(winner)*PKT_WIDTH +: PKT_WIDTH];
                        m_src_id    <= winner;
                        last_grant  <= winner;
                        s_pkt_ack   <= NUM_SRC'(1) << winner;
                        m_pkt_valid <= 1'b1;
                        busy        <= 1'b1;
                        state       <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    timer <= '0;
                    state <= ST_WAIT;
                end

                ST_WAIT: begin
                    timer <= timer + TMR_W'(1);
                    // Completion takes priority over a coincident timeout
                    if (m_pkt_ready) begin
                        done_count <= done_count + CNT_WIDTH'(1);
                        busy       <= 1'b0;
                        state      <= ST_IDLE;
                    end else if (timer == TMR_LAST) begin
                        timeout_pulse <= 1'b1;
                        timeout_count <= timeout_count + CNT_WIDTH'(1);
                        busy          <= 1'b0;
                        state         <= ST_IDLE;
                    end
                end

                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
